// File: rtl/popcount_expander.sv
// Two-stage valid/ready pipeline that expands a population count into a
// thermometer word. Define POPCOUNT_EXPANDER_SAT_EN to saturate overflowing counts.
module popcount_expander #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_count,
    input  logic             in_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits,
    output logic             out_overflow
);

    logic             s1_valid_q, s1_valid_d;
    logic [CW-1:0]    s1_count_q, s1_count_d;
    logic             s1_msb_q,   s1_msb_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_bits_q,  s2_bits_d;
    logic             s2_ovf_q,   s2_ovf_d;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] lsb_word;
    logic [WIDTH-1:0] msb_word;
    logic [WIDTH-1:0] dec_word;
    logic             dec_ovf;

    // Handshake: S1 may take a new count whenever it is empty or moving into S2.
    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
        s1_load  = in_valid && in_ready;
    end

    // Thermometer decode of the S1 count; the MSB form is the bit-reversed LSB form.
    always_comb begin
        lsb_word = '0;
        msb_word = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            lsb_word[i] = (32'(i) < 32'(s1_count_q));
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            msb_word[i] = lsb_word[int'(WIDTH) - 1 - i];
        end
        dec_ovf = (32'(s1_count_q) > WIDTH);
        if (dec_ovf) begin
`ifdef POPCOUNT_EXPANDER_SAT_EN
            dec_word = '1;
`else
            dec_word = '0;
`endif
        end else begin
            dec_word = s1_msb_q ? msb_word : lsb_word;
        end
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_count_d = s1_count_q;
        s1_msb_d   = s1_msb_q;
        s2_valid_d = s2_valid_q;
        s2_bits_d  = s2_bits_q;
        s2_ovf_d   = s2_ovf_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_count_d = in_count;
            s1_msb_d   = in_msb;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_bits_d  = dec_word;
            s2_ovf_d   = dec_ovf;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_count_q <= '0;
            s1_msb_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_bits_q  <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_count_q <= s1_count_d;
            s1_msb_q   <= s1_msb_d;
            s2_valid_q <= s2_valid_d;
            s2_bits_q  <= s2_bits_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_bits     = s2_bits_q;
    assign out_overflow = s2_ovf_q;

endmodule

// File: tb/tb_popcount_expander.sv
// Scoreboard bench for popcount_expander: randomized counts and handshakes
// checked against an arithmetic reference model.
module tb_popcount_expander;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CW    = 6;

    typedef struct {
        logic [WIDTH-1:0] bits;
        logic             ovf;
        int               c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CW-1:0]    in_count = '0;
    logic             in_msb = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_bits;
    logic             out_overflow;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;
    int   n_out    = 0;
    bit   rnd_on   = 1'b0;

    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_bits  = '0;
    logic             prev_ovf   = 1'b0;

    popcount_expander #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .in_msb(in_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: c ones packed at one end, computed with plain 64-bit arithmetic.
    function automatic exp_t model(input int c, input bit m);
        exp_t e;
        longint unsigned ones;
        e.c   = c;
        e.ovf = (c > int'(WIDTH));
        if (e.ovf) begin
`ifdef POPCOUNT_EXPANDER_SAT_EN
            e.bits = '1;
`else
            e.bits = '0;
`endif
        end else begin
            ones = (64'd1 << c) - 64'd1;
            if (m) ones = ones << (int'(WIDTH) - c);
            e.bits = ones[WIDTH-1:0];
        end
        return e;
    endfunction

    // Input monitor: inputs are stable at the falling edge, so this sees the next transfer.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(model(int'(in_count), in_msb));
            n_acc++;
        end
    end

    // Output monitor: hold-stability while stalled, then scoreboard compare on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_bits", 64'(out_bits), 64'(prev_bits));
                chk("hold_ovf", 64'(out_overflow), 64'(prev_ovf));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_bits), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bits", 64'(out_bits), 64'(e.bits));
                    chk("out_overflow", 64'(out_overflow), 64'(e.ovf));
`ifdef POPCOUNT_EXPANDER_SAT_EN
                    chk("popcount", 64'($countones(out_bits)), 64'((e.c > int'(WIDTH)) ? int'(WIDTH) : e.c));
`else
                    if (!e.ovf) chk("popcount", 64'($countones(out_bits)), 64'(e.c));
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bits  = out_bits;
            prev_ovf   = out_overflow;
        end
    end

    // Present one count and hold it until accepted; entered and left at posedge+1.
    task automatic send(input int c, input bit m);
        int w = 0;
        in_valid = 1'b1;
        in_count = CW'(c);
        in_msb   = m;
        @(negedge clk);
        while (!in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bits", 64'(out_bits), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge N, visible after edge N+1.
        in_valid = 1'b1;
        in_count = CW'(7);
        in_msb   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_n", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n1_valid", 64'(out_valid), 64'd1);
        chk("lat_n1_bits", 64'(out_bits), 64'h7F);
        drain();

        // Streaming sweep at full rate.
        base = n_out;
        for (int c = 0; c <= int'(WIDTH); c++) send(c, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("sweep_throughput", 64'(n_out - base), 64'(WIDTH + 1));
        drain();

        // MSB packing and overflow followed by a normal word.
        send(5, 1'b1);
        send(1, 1'b1);
        send(32, 1'b1);
        send(40, 1'b0);
        send(63, 1'b1);
        send(3, 1'b0);
        drain();

        // Backpressure: two words fill the pipe, then in_ready falls.
        base = n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msb    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_count = CW'(10 + k);
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(n_acc - base), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_passthrough", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with two words in flight discards both.
        out_ready = 1'b0;
        send(9, 1'b0);
        send(11, 1'b1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_bits", 64'(out_bits), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready_back", 64'(in_ready), 64'd1);
        base = n_out;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_ghost", 64'(n_out - base), 64'd0);

        // Random traffic with random backpressure.
        base   = n_out;
        rnd_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    int gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    send(($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 63))
                                                     : int'($urandom_range(0, 32)),
                         1'($urandom_range(0, 1)));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        chk("random_count", 64'(n_out - base), 64'd10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcount_expander.md
# popcount_expander

Inverse of the 32-input ones-counter. It takes a 6-bit population count and produces a 32-bit thermometer word containing exactly that many ones, packed at the LSB or MSB end. The block sits on the producer side of the count datapath and regenerates unary bit vectors for the balanced datapath that re-counts them. It is a 2-stage valid/ready pipeline with full throughput and backpressure.

## Interface
Parameters:
- WIDTH, 32, output word width; the count range is 0..WIDTH.
- CW, 6, count width; must satisfy 2^CW > WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a count is presented.
- in_ready  output  1  the block accepts the count this cycle.
- in_count  input  CW  requested number of ones.
- in_msb  input  1  0: ones packed from bit 0 upward; 1: ones packed from bit WIDTH-1 downward.
- out_valid  output  1  out_bits and out_overflow are valid.
- out_ready  input  1  the consumer accepts the output this cycle.
- out_bits  output  WIDTH  thermometer word.
- out_overflow  output  1  the count exceeded WIDTH.

## Operation
- Stage S1 registers {in_count, in_msb} and a valid bit.
- Stage S2 registers the decoded word, the overflow bit and a valid bit.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Advance rules:
  - S2 loads from S1 when S1 is valid and (S2 is empty or out_ready is high).
  - S1 loads from the input when S1 is empty or S1 advances in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational and depends on out_ready.
- Decode for in_msb=0 and count c in 0..WIDTH: out_bits[i] = (i < c).
- Decode for in_msb=1: out_bits[i] = (i >= WIDTH-c).
- c=0 yields all zeros. c=WIDTH yields all ones.
- For c > WIDTH (33..63): out_overflow=1 and out_bits follow the Configuration section.
- The popcount of out_bits always equals min(c, WIDTH) when saturation is compiled in.
- While out_valid=1 and out_ready=0, out_bits and out_overflow hold stable.
- No data is dropped or duplicated under any valid/ready pattern.

## Timing
- Reset values, applied asynchronously while rst=1:
  - out_valid=0, out_bits=0, out_overflow=0.
  - Both stage valid bits are 0.
  - in_ready is forced to 0 while rst=1.
- in_ready returns to 1 in the first cycle after rst deasserts.
- Latency: a count accepted at edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles, provided out_ready stays high.
- Throughput is 1 word per cycle while out_ready=1.
- Full condition: both stages hold data and out_ready=0, so in_ready=0.
  - Raising out_ready re-enables in_ready in the same cycle (pass-through).
- Simultaneous events:
  - An output transfer, S1→S2 move and input transfer can all occur on the same edge. All three complete.
  - An input transfer together with an output transfer while only S2 is full: S1 loads and S2 empties. out_valid drops for one cycle.
- Reset mid-operation discards both stages. No partial word is emitted afterward.

## Configuration
Macro: POPCOUNT_EXPANDER_SAT_EN.
- Defined: an overflowing count saturates. out_bits is all ones and out_overflow=1.
- Undefined: an overflowing count yields out_bits=0 and out_overflow=1. The consumer must discard the word.
- In both builds, out_overflow is 0 for every count in 0..WIDTH. Only overflow handling differs.

## Test plan
- Reset then idle: rst pulse mid-stream with 2 words in flight → out_valid=0 and out_bits=0 immediately. in_ready=1 one cycle after rst falls, and the in-flight words never appear.
- Streaming sweep: c=0..32 back-to-back with in_msb=0, out_ready=1 → outputs arrive 2 cycles later at 1 per cycle.
  - c=5 gives 0x0000001F.
  - c=32 gives 0xFFFFFFFF.
  - c=0 gives 0x00000000.
- MSB packing: c=5 with in_msb=1 → 0xF8000000. c=1 with in_msb=1 → 0x80000000.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 → in_ready falls after 2 words are accepted and out_bits stays stable. Release out_ready → words drain in order with no loss.
- Overflow: c=40 → out_overflow=1.
  - Saturating build: out_bits=0xFFFFFFFF.
  - Non-saturating build: out_bits=0x00000000.
  - Next word c=3 → 0x00000007 with out_overflow=0.
- Random valid/ready toggling over 10k words → scoreboard confirms popcount(out_bits)=min(c,32), order is preserved and nothing is dropped.
